i2c_slave_phy: RTL
==================

# i2c_slave_phy

Bit-level I2C target front end for the LED driver. It samples the raw SCL/SDA bus pins, detects START/STOP conditions, and deserialises bytes MSB-first. It drives ACK/NACK on SDA and presents `start`, `stop`, `rx_valid` and `rx_data` pulses directly to `i2c_controller`, which sits immediately downstream. The block is write-only: it never drives read data and never stretches SCL.

## Interface
- `DEVICE_ADDR`, default 7'h40: 7-bit target address that is ACKed; must equal the controller's `DEVICE_ADDR`.
- `clk`  in  1  system clock (100 MHz nominal).
- `reset`  in  1  synchronous reset, active-high.
- `scl_in`  in  1  raw SCL pin; asynchronous to `clk`.
- `sda_in`  in  1  raw SDA pin; asynchronous to `clk`.
- `sda_oe`  out  1  pulls SDA low when 1; release (bus reads high) when 0.
- `start`  out  1  one-cycle pulse on START or repeated START.
- `stop`  out  1  one-cycle pulse on STOP ending an active transaction.
- `rx_valid`  out  1  one-cycle pulse when a complete byte has been received.
- `rx_data`  out  8  last received byte; valid while `rx_valid` is 1, held until the next byte.
- `busy`  out  1  high from START until STOP or reset.

## Operation
- **Synchronisation:** each pin passes through a 2-flop synchroniser, plus one history flop (`*_s`, `*_d`). Synchroniser and history flops reset to 1 (idle bus), so releasing reset never produces a false edge.
- **Event decode,** evaluated every `clk` on synchronised values:
  - START: SDA 1→0 while SCL was high in both the current and the previous sample.
  - STOP: SDA 0→1 under the same SCL condition.
  - SCL rise/fall: `scl_s != scl_d`.
  - If SDA and SCL change in the same sample, the SDA change is a data change, not START/STOP.
- **States:**
  - **IDLE:** on START, go to ADDR, clear the bit counter, pulse `start`, set `busy`.
  - **ADDR / DATA:** on each SCL rise, shift `sda_s` into the shift register and increment the 4-bit counter. After the 8th rise, load `rx_data` and pulse `rx_valid`.
    - In ADDR, the address byte always produces `rx_valid`, whether or not it matches.
    - In ADDR, if `byte[7:1] == DEVICE_ADDR` and `byte[0] == 0`, the byte is ACKed. Otherwise it is NACKed and the FSM enters IGNORE after the 9th bit.
  - **ACK:** `sda_oe` asserts on the first SCL fall after the 8th rise (ACK case only) and deasserts on the next SCL fall. The FSM then goes to DATA with the counter cleared.
  - **DATA bytes** are always ACKed.
  - **IGNORE:** no `rx_valid`, `sda_oe` held at 0; the FSM leaves only on START or STOP.
- **Repeated START,** in any non-IDLE state including mid-byte or during ACK:
  - pulse `start`;
  - drop `sda_oe`;
  - clear the counter and discard the partial byte;
  - go to ADDR.
- **STOP,** in any non-IDLE state:
  - pulse `stop`;
  - drop `sda_oe`;
  - discard the partial byte, clear `busy`;
  - go to IDLE.
  - A STOP seen while already in IDLE produces no pulse.
- `start`, `stop` and `rx_valid` are mutually exclusive in any cycle.
- The counter only counts 0..8 and saturates; it cannot wrap because a 9th SCL fall always returns it to 0.

## Timing
- **Reset values:** `sda_oe`=0, `start`=0, `stop`=0, `rx_valid`=0, `rx_data`=8'h00, `busy`=0, FSM=IDLE, counter=0. Reset asserted mid-transaction releases SDA on the next `clk` edge.
- **Latency:** `start`/`stop`/`rx_valid` are registered and assert 4 `clk` edges after the first edge that samples the causing pin transition (2 sync + 1 history + 1 output register).
- **ACK drive latency:** `sda_oe` changes 4 `clk` edges after the sampled SCL fall.
- **Bus requirements:** SCL high and low phases ≥ 8 `clk` cycles each; SDA setup/hold relative to SCL ≥ 2 `clk` cycles. Standard mode (100 kHz) and Fast mode (400 kHz) at 100 MHz satisfy this.
- **Pulse spacing:** `rx_valid` pulses are at least 9 SCL periods apart, so the controller never sees back-to-back bytes.

## Test plan
1. START, 0x80, 0x01, 0xAA, STOP at 400 kHz:
   - `start` pulse;
   - `rx_valid` ×3 with `rx_data` 0x80, 0x01, 0xAA;
   - `sda_oe` high during each 9th bit;
   - `stop` pulse;
   - `busy` 1→0.
2. START, 0x82 (address 0x41), 0x05, STOP:
   - `rx_valid` once with 0x82;
   - `sda_oe` stays 0 throughout;
   - no further `rx_valid`;
   - `stop` pulses.
3. START, 0x81 (read bit):
   - NACK (`sda_oe` 0);
   - IGNORE entered;
   - no data bytes delivered.
4. START, 0x80, 4 bits of 0x01, repeated START, 0x80, 0x07, 0x55, STOP:
   - partial byte discarded;
   - `start` pulses twice;
   - `rx_valid` delivers 0x80, 0x80, 0x07, 0x55.
5. STOP injected during the ACK of byte 2:
   - `sda_oe` drops with `stop`;
   - FSM returns to IDLE;
   - the next full transaction (item 1 sequence) succeeds.
6. Assert `reset` mid-DATA while `sda_oe`=1:
   - all outputs zero on the next edge;
   - no `start` pulse at reset release with the bus idle high.

Source files
------------

// File: rtl/i2c_slave_phy.sv
// Bit-level I2C target front end: synchronises SCL/SDA, decodes START/STOP,
// deserialises bytes MSB-first and drives ACK/NACK on SDA (write-only).
// Ports: clk, reset (sync, active-high); scl_in/sda_in raw pins;
//   sda_oe pulls SDA low; start/stop/rx_valid one-cycle pulses;
//   rx_data last received byte; busy high from START until STOP.
module i2c_slave_phy #(
  parameter logic [6:0] DEVICE_ADDR = 7'h40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       start,
  output logic       stop,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ACK1,
    S_ACK2,
    S_IGN
  } state_t;

  // synchroniser (m, s) plus history (d); idle bus level is 1
  logic scl_m_q, scl_s_q, scl_d_q;
  logic sda_m_q, sda_s_q, sda_d_q;

  // decoded bus events, registered once before the FSM
  logic ev_start_q, ev_stop_q, ev_rise_q, ev_fall_q, ev_sda_q;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_q, ack_d;
  logic       oe_q, oe_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       rv_q, rv_d;
  logic [7:0] rxd_q, rxd_d;
  logic       busy_q, busy_d;

  logic       scl_hi;
  logic       start_det, stop_det;
  logic       rise_det, fall_det;
  logic [7:0] byte_w;
  logic       match;

  // an SDA edge only counts as START/STOP when SCL was stable high,
  // so a simultaneous SCL/SDA change is treated as data
  assign scl_hi    = scl_s_q & scl_d_q;
  assign start_det = scl_hi & sda_d_q & ~sda_s_q;
  assign stop_det  = scl_hi & ~sda_d_q & sda_s_q;
  assign rise_det  = scl_s_q & ~scl_d_q;
  assign fall_det  = ~scl_s_q & scl_d_q;

  assign byte_w = {shift_q[6:0], ev_sda_q};
  assign match  = (byte_w[7:1] == DEVICE_ADDR) & ~byte_w[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ack_d   = ack_q;
    oe_d    = oe_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    rv_d    = 1'b0;
    rxd_d   = rxd_q;
    busy_d  = busy_q;
    if (ev_start_q) begin
      state_d = S_ADDR;
      cnt_d   = 4'd0;
      shift_d = 8'h00;
      oe_d    = 1'b0;
      start_d = 1'b1;
      busy_d  = 1'b1;
    end else if (ev_stop_q) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        shift_d = 8'h00;
        oe_d    = 1'b0;
        stop_d  = 1'b1;
        busy_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_ADDR, S_DATA: begin
          if (ev_rise_q) begin
            shift_d = byte_w;
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd8;
              rv_d    = 1'b1;
              rxd_d   = byte_w;
              ack_d   = (state_q == S_DATA) | match;
              state_d = S_ACK1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        // end of the 8th bit: drive ACK for the 9th
        S_ACK1: begin
          if (ev_fall_q) begin
            oe_d    = ack_q;
            state_d = S_ACK2;
          end
        end
        // end of the 9th bit: release and move on
        S_ACK2: begin
          if (ev_fall_q) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = ack_q ? S_DATA : S_IGN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_m_q    <= 1'b1;
      scl_s_q    <= 1'b1;
      scl_d_q    <= 1'b1;
      sda_m_q    <= 1'b1;
      sda_s_q    <= 1'b1;
      sda_d_q    <= 1'b1;
      ev_start_q <= 1'b0;
      ev_stop_q  <= 1'b0;
      ev_rise_q  <= 1'b0;
      ev_fall_q  <= 1'b0;
      ev_sda_q   <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ack_q      <= 1'b0;
      oe_q       <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rv_q       <= 1'b0;
      rxd_q      <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      scl_m_q    <= scl_in;
      scl_s_q    <= scl_m_q;
      scl_d_q    <= scl_s_q;
      sda_m_q    <= sda_in;
      sda_s_q    <= sda_m_q;
      sda_d_q    <= sda_s_q;
      ev_start_q <= start_det;
      ev_stop_q  <= stop_det;
      ev_rise_q  <= rise_det;
      ev_fall_q  <= fall_det;
      ev_sda_q   <= sda_s_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ack_q      <= ack_d;
      oe_q       <= oe_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      rv_q       <= rv_d;
      rxd_q      <= rxd_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe   = oe_q;
  assign start    = start_q;
  assign stop     = stop_q;
  assign rx_valid = rv_q;
  assign rx_data  = rxd_q;
  assign busy     = busy_q;

endmodule
